// File: rtl/machine_host_seq.sv
// Host sequencer for the image machine: loads the source image from a sync-read ROM, waits for
// end_process, then streams the downsampled result. Optional watchdog: MACHINE_HOST_TIMEOUT_EN.
module machine_host_seq #(
  parameter int IMG_PIXELS  = 65536,
  parameter int OUT_PIXELS  = 16129,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int READ_WAIT   = 2,
  parameter int TIMEOUT_CYC = 1 << 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [DATA_W-1:0] src_rd_data,
  output logic [1:0]        m_status,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_end_process,
  input  logic [DATA_W-1:0] m_out,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int HOLD_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(IMG_PIXELS - 1);
  localparam logic [ADDR_W-1:0] OUT_LAST  = ADDR_W'(OUT_PIXELS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(READ_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PROC,
    S_GAP,
    S_READ,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] cnt;   // pixel index in LOAD, result index in READ
  logic [HOLD_W-1:0] hold;
  logic              load_last;
  logic              sample;
  logic              read_last;
  logic              timeout;

  assign load_last = (state == S_LOAD) && (cnt == LOAD_LAST);
  assign sample    = (state == S_READ) && (hold == HOLD_LAST);
  assign read_last = sample && (cnt == OUT_LAST);

`ifdef MACHINE_HOST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // end_process on the final watchdog cycle still wins over the timeout
  assign timeout = (state == S_PROC) && !m_end_process && (tmo_cnt == TMO_LAST);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_PROC) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                 tmo_cnt <= '0;
      if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    m_status    = 2'b00;
    m_addr      = '0;
    m_data      = '0;
    src_rd_addr = '0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        m_status    = 2'b10;
        m_addr      = cnt;
        m_data      = src_rd_data;
        src_rd_addr = cnt + ADDR_W'(1);
        if (load_last) state_next = S_PROC;
      end
      S_PROC: begin
        m_status = 2'b01;
        if (m_end_process) state_next = S_GAP;
        else if (timeout)  state_next = S_DONE;
      end
      S_GAP: begin
        m_status   = 2'b01;
        state_next = S_READ;
      end
      S_READ: begin
        m_status = 2'b11;
        m_addr   = cnt;
        if (read_last) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Result is registered, so res_valid lands in the first hold cycle of the next index
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      hold      <= '0;
      res_valid <= 1'b0;
      res_addr  <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_LOAD: begin
          cnt <= load_last ? '0 : cnt + ADDR_W'(1);
        end
        S_READ: begin
          if (sample) begin
            res_valid <= 1'b1;
            res_addr  <= cnt;
            res_data  <= m_out;
            hold      <= '0;
            cnt       <= cnt + ADDR_W'(1);
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
        default: begin
          cnt  <= '0;
          hold <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_machine_host_seq.sv
// Directed bench for machine_host_seq with a small image (16 in, 4 out) and simple ROM/machine models.
module tb_machine_host_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_rd_addr;
  logic [7:0]  src_rd_data;
  logic [1:0]  m_status;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  logic        m_end_process;
  logic [7:0]  m_out;
  logic        res_valid;
  logic [15:0] res_addr;
  logic [7:0]  res_data;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic       ep_en;
  logic [7:0] proc_cnt;
  logic [7:0] rom_q;

  always #5 clk = ~clk;

  machine_host_seq #(
    .IMG_PIXELS (16),
    .OUT_PIXELS (4),
    .ADDR_W     (16),
    .DATA_W     (8),
    .READ_WAIT  (2),
    .TIMEOUT_CYC(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .src_rd_addr  (src_rd_addr),
    .src_rd_data  (src_rd_data),
    .m_status     (m_status),
    .m_addr       (m_addr),
    .m_data       (m_data),
    .m_end_process(m_end_process),
    .m_out        (m_out),
    .res_valid    (res_valid),
    .res_addr     (res_addr),
    .res_data     (res_data),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  // Sync-read ROM: rom[i] = i + 8'h40
  always_ff @(posedge clk) rom_q <= 8'h40 + src_rd_addr[7:0];
  assign src_rd_data = rom_q;

  // Machine: end_process rises 5 cycles into status 01; read data = addr*3
  always_ff @(posedge clk) begin
    if (m_status == 2'b01) proc_cnt <= proc_cnt + 8'd1;
    else                   proc_cnt <= 8'd0;
  end
  assign m_end_process = ep_en && (proc_cnt >= 8'd5);
  assign m_out = m_addr[7:0] * 8'd3;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (got hang, want finish)");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    ep_en = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({m_status, busy, done, err, res_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got status=%b busy=%b done=%b err=%b rv=%b, want all 0",
               m_status, busy, done, err, res_valid);
    end
    n_cmp++;
    if ({m_addr, src_rd_addr} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_addr: got m_addr=%h src=%h, want 0/0", m_addr, src_rd_addr);
    end
    n_cmp++;
    if ({res_addr, res_data} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_res: got res_addr=%h res_data=%h, want 0/0", res_addr, res_data);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m_status, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: got status=%b busy=%b, want 00/0", m_status, busy);
    end
  endtask

  // Full run; poke=1 pulses start during LOAD and READ, which must be ignored
  task automatic run_full(input bit poke);
    int  n01;
    int  pulses;
    int  t;
    int  last_t;
    bit  seen_done;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if ({m_status, m_addr, m_data} !== {2'b10, 16'(j), 8'(8'h40 + j)}) begin
        n_fail++;
        $display("FAIL load_j%0d: got status=%b addr=%h data=%h, want 10/%h/%h",
                 j, m_status, m_addr, m_data, 16'(j), 8'(8'h40 + j));
      end
      n_cmp++;
      if ({busy, src_rd_addr} !== {1'b1, 16'(j + 1)}) begin
        n_fail++;
        $display("FAIL load_src_j%0d: got busy=%b src=%h, want 1/%h", j, busy, src_rd_addr, 16'(j + 1));
      end
      start = (poke && j == 5);
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if ({m_status, m_addr} !== {2'b01, 16'h0}) begin
      n_fail++;
      $display("FAIL proc_entry: got status=%b addr=%h, want 01/0000", m_status, m_addr);
    end
    n01 = 0;
    while (m_status == 2'b01 && n01 < 200) begin
      n01++;
      @(negedge clk);
    end
    n_cmp++;
    if (n01 !== 7) begin
      n_fail++;
      $display("FAIL proc_gap_len: got %0d cycles of status 01, want 7", n01);
    end
    n_cmp++;
    if (m_status !== 2'b11) begin
      n_fail++;
      $display("FAIL read_entry: got status=%b, want 11", m_status);
    end
    pulses = 0;
    t = 0;
    last_t = 0;
    seen_done = 1'b0;
    while (!seen_done && t < 60) begin
      start = (poke && t == 1);
      if (res_valid) begin
        n_cmp++;
        if ({res_addr, res_data} !== {16'(pulses), 8'(pulses * 3)}) begin
          n_fail++;
          $display("FAIL res_%0d: got addr=%h data=%h, want %h/%h",
                   pulses, res_addr, res_data, 16'(pulses), 8'(pulses * 3));
        end
        if (pulses > 0) begin
          n_cmp++;
          if (t - last_t !== 2) begin
            n_fail++;
            $display("FAIL res_spacing_%0d: got %0d cycles, want 2", pulses, t - last_t);
          end
        end
        last_t = t;
        pulses++;
      end
      if (done) begin
        seen_done = 1'b1;
        n_cmp++;
        if ({res_valid, m_status, busy} !== {1'b1, 2'b00, 1'b1}) begin
          n_fail++;
          $display("FAIL done_cycle: got rv=%b status=%b busy=%b, want 1/00/1", res_valid, m_status, busy);
        end
      end
      t++;
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (!seen_done || pulses !== 4) begin
      n_fail++;
      $display("FAIL readout_count: got done=%b pulses=%0d, want 1/4", seen_done, pulses);
    end
    n_cmp++;
    if ({busy, done, m_status, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL after_done: got busy=%b done=%b status=%b err=%b, want 0/0/00/0",
               busy, done, m_status, err);
    end
  endtask

  task automatic test_load_process_readout();
    run_full(1'b0);
  endtask

  task automatic test_start_while_busy();
    run_full(1'b1);
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    n_cmp++;
    if ({m_status, m_addr} !== {2'b10, 16'd7}) begin
      n_fail++;
      $display("FAIL midload_pos: got status=%b addr=%h, want 10/0007", m_status, m_addr);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m_status, busy, m_addr, src_rd_addr} !== {2'b00, 1'b0, 16'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL midload_reset: got status=%b busy=%b addr=%h src=%h, want 00/0/0/0",
               m_status, busy, m_addr, src_rd_addr);
    end
    reset = 1'b0;
    run_full(1'b0);
  endtask

  task automatic test_timeout();
    int n01;
    ep_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
`ifdef MACHINE_HOST_TIMEOUT_EN
    n01 = 0;
    while (m_status == 2'b01 && n01 < 200) begin
      n_cmp++;
      if (res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_no_res: got res_valid=1 in PROC, want 0");
      end
      n01++;
      @(negedge clk);
    end
    n_cmp++;
    if (n01 !== 32) begin
      n_fail++;
      $display("FAIL tmo_len: got %0d PROC cycles, want 32", n01);
    end
    n_cmp++;
    if ({done, err, m_status, res_valid} !== {1'b1, 1'b1, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL tmo_done: got done=%b err=%b status=%b rv=%b, want 1/1/00/0",
               done, err, m_status, res_valid);
    end
    @(negedge clk);
    start = 1'b1;
    n_cmp++;
    if ({busy, err} !== 2'b01) begin
      n_fail++;
      $display("FAIL tmo_idle: got busy=%b err=%b, want 0/1", busy, err);
    end
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({m_status, err} !== {2'b10, 1'b1}) begin
      n_fail++;
      $display("FAIL tmo_sticky: got status=%b err=%b, want 10/1", m_status, err);
    end
`else
    n01 = 0;
    repeat (100) @(negedge clk);
    n_cmp++;
    if ({m_status, busy, err, done} !== {2'b01, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL proc_wait: got status=%b busy=%b err=%b done=%b, want 01/1/0/0",
               m_status, busy, err, done);
    end
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ep_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m_status, busy, err} !== 4'b0) begin
      n_fail++;
      $display("FAIL tmo_reset_clear: got status=%b busy=%b err=%b, want 00/0/0", m_status, busy, err);
    end
  endtask

  initial begin
    test_reset();
    test_load_process_readout();
    test_start_while_busy();
    test_reset_mid_load();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
